// File: rtl/if_fetch_ctrl.sv
// P5 fetch-stage controller: PC register, ROM addressing, stall/redirect, address range check.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned IM_WORDS    = 4096,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] im_addr,
  output logic [31:0] instr_F,
  output logic [31:0] pc_F,
  output logic        valid_F,
  output logic        addr_err,
  output logic [31:0] err_pc,
  output logic        halted
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_redirect
`endif
);

  localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [31:0] pc_offset;
  logic        addr_ok;
  logic        run;

  // Offset is taken in full 32 bits so wrapped/low addresses fail the range test.
  assign pc_offset = pc_q - RESET_PC;
  assign addr_ok   = (pc_q[1:0] == 2'b00) && (pc_q >= RESET_PC) && (pc_offset < IM_BYTES);
  assign run       = (state_q == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      addr_err_q <= 1'b0;
      err_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_err_q <= addr_err_d;
      err_pc_q   <= err_pc_d;
    end
  end

  // Next state, next PC and sticky error capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_err_d = addr_err_q;
    err_pc_d   = err_pc_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (redirect_valid) pc_d = redirect_pc;
          else                pc_d = pc_q + 32'd4;
        end
        if (!addr_ok) begin
          if (!addr_err_q) begin
            addr_err_d = 1'b1;
            err_pc_d   = pc_q;
          end
          if (HALT_ON_ERR) state_d = S_HALT;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // IF/ID boundary is combinational; the pipeline register sits outside this block.
  assign im_addr  = pc_q;
  assign pc_F     = pc_q;
  assign valid_F  = run && addr_ok;
  assign instr_F  = valid_F ? im_instr : 32'h0;
  assign addr_err = addr_err_q;
  assign err_pc   = err_pc_q;
  assign halted   = (state_q == S_HALT);

`ifdef IF_FETCH_PERF_EN
  logic redirect_take;
  assign redirect_take = run && !stall && redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch    <= 32'h0;
      perf_stall    <= 32'h0;
      perf_redirect <= 32'h0;
    end else begin
      if (valid_F && !stall) perf_fetch    <= perf_fetch + 32'd1;
      if (run && stall)      perf_stall    <= perf_stall + 32'd1;
      if (redirect_take)     perf_redirect <= perf_redirect + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: instance a halts on error, instance b keeps fetching.
module tb_if_fetch_ctrl;

  typedef struct {
    bit          sel;
    bit          rst;
    bit          st;
    bit          rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    bit          ev;
    bit          ee;
    logic [31:0] eep;
    bit          eh;
    bit          cp;
    logic [31:0] pf;
    logic [31:0] ps;
    logic [31:0] pr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, st_a = 1'b0, rv_a = 1'b0;
  logic        rst_b = 1'b1, st_b = 1'b0, rv_b = 1'b0;
  logic [31:0] rpc_a = 32'h0, rpc_b = 32'h0;
  logic [31:0] im_addr_a, instr_a, pc_a, err_pc_a, im_instr_a;
  logic [31:0] im_addr_b, instr_b, pc_b, err_pc_b, im_instr_b;
  logic        valid_a, aerr_a, halted_a, valid_b, aerr_b, halted_b;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] pf_a, ps_a, pr_a, pf_b, ps_b, pr_b;
`endif

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign im_instr_a = rom(im_addr_a);
  assign im_instr_b = rom(im_addr_b);

  if_fetch_ctrl #(.RESET_PC(32'h0000_3000), .IM_WORDS(4096), .HALT_ON_ERR(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .stall(st_a), .redirect_valid(rv_a), .redirect_pc(rpc_a),
    .im_instr(im_instr_a), .im_addr(im_addr_a), .instr_F(instr_a), .pc_F(pc_a),
    .valid_F(valid_a), .addr_err(aerr_a), .err_pc(err_pc_a), .halted(halted_a)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch(pf_a), .perf_stall(ps_a), .perf_redirect(pr_a)
`endif
  );

  if_fetch_ctrl #(.RESET_PC(32'h0000_3000), .IM_WORDS(4096), .HALT_ON_ERR(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .stall(st_b), .redirect_valid(rv_b), .redirect_pc(rpc_b),
    .im_instr(im_instr_b), .im_addr(im_addr_b), .instr_F(instr_b), .pc_F(pc_b),
    .valid_F(valid_b), .addr_err(aerr_b), .err_pc(err_pc_b), .halted(halted_b)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch(pf_b), .perf_stall(ps_b), .perf_redirect(pr_b)
`endif
  );

  vec_t stim_q[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit sel, input bit rst, input bit st, input bit rv,
                     input logic [31:0] rpc, input logic [31:0] epc, input bit ev,
                     input bit ee, input logic [31:0] eep, input bit eh, input bit cp,
                     input logic [31:0] pf, input logic [31:0] ps, input logic [31:0] pr);
    vec_t v;
    v.sel = sel; v.rst = rst; v.st = st; v.rv = rv; v.rpc = rpc;
    v.epc = epc; v.ev = ev; v.ee = ee; v.eep = eep; v.eh = eh;
    v.cp = cp; v.pf = pf; v.ps = ps; v.pr = pr;
    stim_q.push_back(v);
  endtask

  // Monitor: pops one expected record per cycle and compares mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      logic [31:0] e_instr;
      e = exp_q.pop_front();
      e_instr = e.ev ? rom(e.epc) : 32'h0;
      if (!e.sel) begin
        chk("a.im_addr", im_addr_a, e.epc);
        chk("a.pc_F", pc_a, e.epc);
        chk("a.valid_F", 32'(valid_a), 32'(e.ev));
        chk("a.instr_F", instr_a, e_instr);
        chk("a.addr_err", 32'(aerr_a), 32'(e.ee));
        chk("a.err_pc", err_pc_a, e.eep);
        chk("a.halted", 32'(halted_a), 32'(e.eh));
`ifdef IF_FETCH_PERF_EN
        if (e.cp) begin
          chk("a.perf_fetch", pf_a, e.pf);
          chk("a.perf_stall", ps_a, e.ps);
          chk("a.perf_redirect", pr_a, e.pr);
        end
`endif
      end else begin
        chk("b.im_addr", im_addr_b, e.epc);
        chk("b.pc_F", pc_b, e.epc);
        chk("b.valid_F", 32'(valid_b), 32'(e.ev));
        chk("b.instr_F", instr_b, e_instr);
        chk("b.addr_err", 32'(aerr_b), 32'(e.ee));
        chk("b.err_pc", err_pc_b, e.eep);
        chk("b.halted", 32'(halted_b), 32'(e.eh));
      end
    end
  end

  initial begin
    int wait_cnt;
    // Instance a: reset, boot, free-run, stall, redirect, bad redirect -> HALT.
    //   sel rst st rv rpc           im_addr       v  e  err_pc        h  cp pf  ps  pr
    add(0, 1, 0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0,        0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3000, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3004, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3008, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        32'h0000_300C, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        32'h0000_300C, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        32'h0000_300C, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_300C, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3010, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_3040, 32'h0000_3014, 1, 0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h0000_3080, 32'h0000_3040, 1, 0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_3042, 32'h0000_3040, 1, 0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3042, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3046, 0, 1, 32'h0000_3042, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_3100, 32'h0000_3046, 0, 1, 32'h0000_3042, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3046, 0, 1, 32'h0000_3042, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 32'h0,        32'h0000_3046, 0, 1, 32'h0000_3042, 1, 0, 0, 0, 0);
    // Post-reset: 10 RUN cycles with 2 stalls and 1 redirect.
    add(0, 0, 0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0,        0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3000, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        32'h0000_3004, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        32'h0000_3004, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3004, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_3020, 32'h0000_3008, 1, 0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3020, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3024, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3028, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_302C, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3030, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'h0000_3034, 1, 0, 32'h0,        0, 1, 8, 2, 1);
    // Instance b: top-of-ROM boundary, sticky err_pc, 32-bit wrap, recovery.
    add(1, 1, 0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h0000_6FFC, 32'h0000_3000, 1, 0, 32'h0,       0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0000_6FFC, 1, 0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0000_7000, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0000_7004, 0, 1, 32'h0000_7000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0000_7008, 0, 1, 32'h0000_7000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_700C, 0, 1, 32'h0000_7000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 32'h0000_7000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h0000_3008, 32'h0000_0000, 0, 1, 32'h0000_7000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0000_3008, 1, 1, 32'h0000_7000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0000_300C, 1, 1, 32'h0000_7000, 0, 0, 0, 0, 0);

    while (stim_q.size() > 0) begin
      vec_t v;
      v = stim_q.pop_front();
      @(posedge clk);
      #1;
      if (!v.sel) begin
        rst_a = v.rst; st_a = v.st; rv_a = v.rv; rpc_a = v.rpc;
        rst_b = 1'b1;  st_b = 1'b0; rv_b = 1'b0; rpc_b = 32'h0;
      end else begin
        rst_b = v.rst; st_b = v.st; rv_b = v.rv; rpc_b = v.rpc;
        rst_a = 1'b1;  st_a = 1'b0; rv_a = 1'b0; rpc_a = 32'h0;
      end
      exp_q.push_back(v);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
